// File: rtl/logic_pulse_seq_pkg.sv
// logic_pulse_seq_pkg
// Shared types and width defaults for the logic pulse sequencer and the
// downstream repeat controller, so the time and count fields line up.
package logic_pulse_seq_pkg;

  localparam int DEF_CNT_W = 24;
  localparam int DEF_NUM_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    HIGH,
    LOW,
    END
  } seq_state_e;

endpackage

// File: rtl/logic_pulse_seq_if.sv
// logic_pulse_seq_if
// Trigger/config/status bundle of the pulse sequencer.
//   master : trigger source / configuration side (drives strobes and config)
//   slave  : the sequencer (drives pulse output and status)
interface logic_pulse_seq_if
  import logic_pulse_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int NUM_W = DEF_NUM_W
);

  logic             io_mainTrigger;
  logic             io_rptEn;
  logic             io_abort;
  logic [NUM_W-1:0] io_pulseNo;
  logic [CNT_W-1:0] io_delay;
  logic [CNT_W-1:0] io_highTime;
  logic [CNT_W-1:0] io_lowTime;
  logic             io_pulseOut;
  logic             io_logicEnd;
  logic             io_seqBusy;
  logic [NUM_W-1:0] io_pulseIdx;

  modport master (
    output io_mainTrigger, io_rptEn, io_abort,
    output io_pulseNo, io_delay, io_highTime, io_lowTime,
    input  io_pulseOut, io_logicEnd, io_seqBusy, io_pulseIdx
  );

  modport slave (
    input  io_mainTrigger, io_rptEn, io_abort,
    input  io_pulseNo, io_delay, io_highTime, io_lowTime,
    output io_pulseOut, io_logicEnd, io_seqBusy, io_pulseIdx
  );

endinterface

// File: rtl/logic_pulse_seq_phase_timer.sv
// logic_pulse_seq_phase_timer
// Loadable down-counter shared by the DELAY, HIGH and LOW phases.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : load load_val_i (phase length minus one)
//   load_val_i   : value to load
//   done_o       : count has reached zero (last cycle of the phase)
module logic_pulse_seq_phase_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/logic_pulse_seq.sv
// logic_pulse_seq
// Plays one pulse train: optional start delay, then pulseNo pulses of
// highTime cycles separated by lowTime gaps, then a one-cycle end strobe.
//   io_clk, io_rst : clock, synchronous active-high reset
//   bus (slave)    : triggers, abort, config in; pulse, end, busy, index out
// All outputs are registered from the next-state decode.
//
// state | meaning
// IDLE  | waiting for a start strobe
// DELAY | counting the start delay
// HIGH  | pulse output high
// LOW   | gap between pulses
// END   | one-cycle completion strobe
module logic_pulse_seq
  import logic_pulse_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int NUM_W = DEF_NUM_W
) (
  input  logic         io_clk,
  input  logic         io_rst,
  logic_pulse_seq_if.slave bus
);

  seq_state_e       state_q, state_d;
  logic [NUM_W-1:0] idx_q, idx_d;
  logic [NUM_W-1:0] num_q;
  logic [CNT_W-1:0] hi_q, lo_q;
  logic             pulse_q, end_q, busy_q;

  logic             start, latch;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] hi_in_m1, lo_in_m1;

  assign start = bus.io_mainTrigger | bus.io_rptEn;

  // Phase lengths kept as length-1 so full-scale values load without wrap;
  // a zero width is treated as one cycle.
  assign hi_in_m1 = (bus.io_highTime == '0) ? '0 : bus.io_highTime - 1'b1;
  assign lo_in_m1 = (bus.io_lowTime  == '0) ? '0 : bus.io_lowTime  - 1'b1;

  logic_pulse_seq_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (io_clk),
    .rst_i      (io_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    latch    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && bus.io_pulseNo != '0) begin
          latch    = 1'b1;
          idx_d    = '0;
          tmr_load = 1'b1;
          // The delay is only needed at start, so it goes straight into the timer.
          if (bus.io_delay != '0) begin
            state_d = DELAY;
            tmr_val = bus.io_delay - 1'b1;
          end else begin
            state_d = HIGH;
            tmr_val = hi_in_m1;
          end
        end
      end
      DELAY: begin
        if (tmr_done) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
          tmr_val  = hi_q;
        end
      end
      HIGH: begin
        if (tmr_done) begin
          if (idx_q == num_q - 1'b1) begin
            state_d = END;
          end else begin
            state_d  = LOW;
            tmr_load = 1'b1;
            tmr_val  = lo_q;
          end
        end
      end
      LOW: begin
        if (tmr_done) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
          tmr_val  = hi_q;
          idx_d    = idx_q + 1'b1;
        end
      end
      END: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (bus.io_abort) begin
      state_d  = IDLE;
      idx_d    = '0;
      tmr_load = 1'b0;
      latch    = 1'b0;
    end
  end

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pulse_q <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (latch) begin
        num_q <= bus.io_pulseNo;
        hi_q  <= hi_in_m1;
        lo_q  <= lo_in_m1;
      end
      pulse_q <= (state_d == HIGH);
      end_q   <= (state_d == END);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.io_pulseOut = pulse_q;
  assign bus.io_logicEnd = end_q;
  assign bus.io_seqBusy  = busy_q;
  assign bus.io_pulseIdx = idx_q;

endmodule

// File: tb/tb_logic_pulse_seq.sv
module tb_logic_pulse_seq;

  logic clk;
  logic rst;

  logic_pulse_seq_if #(.CNT_W(24), .NUM_W(16)) bus ();
  logic_pulse_seq_if #(.CNT_W(4),  .NUM_W(4))  bus_s ();

  logic_pulse_seq #(.CNT_W(24), .NUM_W(16)) dut (
    .io_clk (clk),
    .io_rst (rst),
    .bus    (bus)
  );

  logic_pulse_seq #(.CNT_W(4), .NUM_W(4)) dut_s (
    .io_clk (clk),
    .io_rst (rst),
    .bus    (bus_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        busy;
    logic        lend;
    logic        pulse;
    logic        chk;
    logic [15:0] idx;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vec;
  int   miss;

  function automatic exp_t mk(logic b, logic l, logic p, logic c, int idx);
    exp_t r;
    r.busy = b; r.lend = l; r.pulse = p; r.chk = c; r.idx = 16'(idx);
    return r;
  endfunction

  // Expected per-cycle outputs from the cycle after the start edge.
  function automatic void push_seq(int num, int dly, int hi, int lo);
    int hi_e, lo_e;
    hi_e = (hi == 0) ? 1 : hi;
    lo_e = (lo == 0) ? 1 : lo;
    if (num == 0) return;
    for (int d = 0; d < dly; d++) q.push_back(mk(1, 0, 0, 0, 0));
    for (int p = 0; p < num; p++) begin
      for (int h = 0; h < hi_e; h++) q.push_back(mk(1, 0, 1, 1, p));
      if (p != num - 1)
        for (int l = 0; l < lo_e; l++) q.push_back(mk(1, 0, 0, 1, p));
    end
    q.push_back(mk(1, 1, 0, 0, 0));
  endfunction

  function automatic void push_idle(int n, logic chk);
    for (int k = 0; k < n; k++) q.push_back(mk(0, 0, 0, chk, 0));
  endfunction

  task automatic cfg(int n, int d, int h, int l);
    bus.io_pulseNo  = 16'(n);
    bus.io_delay    = 24'(d);
    bus.io_highTime = 24'(h);
    bus.io_lowTime  = 24'(l);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg(1, 0, 1, 1);
    bus.io_mainTrigger = 1'b1;
    push_idle(3, 1);
    for (int i = 1; q.size() != 0; i++) begin
      @(negedge clk);
      e = q.pop_front(); vec++;
      if ({bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut} !== {e.busy, e.lend, e.pulse} ||
          (e.chk && bus.io_pulseIdx !== e.idx)) begin
        miss++;
        $display("FAIL reset cyc %0d: busy/end/pulse/idx got %b%b%b/%0d want %b%b%b/%0d", i,
                 bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut, bus.io_pulseIdx, e.busy, e.lend, e.pulse, e.idx);
      end
    end
    rst = 1'b0;
    bus.io_mainTrigger = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    cfg(3, 0, 2, 3);
    bus.io_mainTrigger = 1'b1;
    push_seq(3, 0, 2, 3);
    push_idle(2, 0);
    for (int i = 1; q.size() != 0; i++) begin
      @(negedge clk);
      bus.io_mainTrigger = 1'b0;
      e = q.pop_front(); vec++;
      if ({bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut} !== {e.busy, e.lend, e.pulse} ||
          (e.chk && bus.io_pulseIdx !== e.idx)) begin
        miss++;
        $display("FAIL basic cyc %0d: busy/end/pulse/idx got %b%b%b/%0d want %b%b%b/%0d", i,
                 bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut, bus.io_pulseIdx, e.busy, e.lend, e.pulse, e.idx);
      end
    end
  endtask

  task automatic test_rpt_delay();
    cfg(1, 5, 0, 7);
    bus.io_rptEn = 1'b1;
    push_seq(1, 5, 0, 7);
    push_idle(2, 0);
    for (int i = 1; q.size() != 0; i++) begin
      @(negedge clk);
      bus.io_rptEn = 1'b0;
      e = q.pop_front(); vec++;
      if ({bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut} !== {e.busy, e.lend, e.pulse} ||
          (e.chk && bus.io_pulseIdx !== e.idx)) begin
        miss++;
        $display("FAIL rpt_delay cyc %0d: busy/end/pulse/idx got %b%b%b/%0d want %b%b%b/%0d", i,
                 bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut, bus.io_pulseIdx, e.busy, e.lend, e.pulse, e.idx);
      end
    end
  endtask

  task automatic test_zero_num();
    cfg(0, 0, 2, 2);
    bus.io_mainTrigger = 1'b1;
    push_idle(6, 1);
    for (int i = 1; q.size() != 0; i++) begin
      @(negedge clk);
      if (i == 3) bus.io_mainTrigger = 1'b0;
      e = q.pop_front(); vec++;
      if ({bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut} !== {e.busy, e.lend, e.pulse} ||
          (e.chk && bus.io_pulseIdx !== e.idx)) begin
        miss++;
        $display("FAIL zero_num cyc %0d: busy/end/pulse/idx got %b%b%b/%0d want %b%b%b/%0d", i,
                 bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut, bus.io_pulseIdx, e.busy, e.lend, e.pulse, e.idx);
      end
    end
  endtask

  task automatic test_retrigger_change();
    cfg(3, 1, 2, 2);
    bus.io_mainTrigger = 1'b1;
    push_seq(3, 1, 2, 2);
    push_idle(3, 0);
    for (int i = 1; q.size() != 0; i++) begin
      @(negedge clk);
      e = q.pop_front(); vec++;
      if ({bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut} !== {e.busy, e.lend, e.pulse} ||
          (e.chk && bus.io_pulseIdx !== e.idx)) begin
        miss++;
        $display("FAIL retrigger cyc %0d: busy/end/pulse/idx got %b%b%b/%0d want %b%b%b/%0d", i,
                 bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut, bus.io_pulseIdx, e.busy, e.lend, e.pulse, e.idx);
      end
      if (i == 1) bus.io_mainTrigger = 1'b0;
      if (i == 3) begin
        bus.io_mainTrigger = 1'b1;
        cfg(5, 4, 9, 9);
      end
      if (i == 6) bus.io_mainTrigger = 1'b0;
    end
  endtask

  task automatic test_abort();
    cfg(3, 0, 3, 2);
    bus.io_mainTrigger = 1'b1;
    push_seq(3, 0, 3, 2);
    while (q.size() > 6) void'(q.pop_back());
    push_idle(6, 1);
    for (int i = 1; q.size() != 0; i++) begin
      @(negedge clk);
      e = q.pop_front(); vec++;
      if ({bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut} !== {e.busy, e.lend, e.pulse} ||
          (e.chk && bus.io_pulseIdx !== e.idx)) begin
        miss++;
        $display("FAIL abort cyc %0d: busy/end/pulse/idx got %b%b%b/%0d want %b%b%b/%0d", i,
                 bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut, bus.io_pulseIdx, e.busy, e.lend, e.pulse, e.idx);
      end
      bus.io_mainTrigger = 1'b0;
      bus.io_abort       = 1'b0;
      if (i == 6) bus.io_abort = 1'b1;
      if (i == 8) begin
        bus.io_abort       = 1'b1;
        bus.io_mainTrigger = 1'b1;
      end
    end
  endtask

  task automatic test_back_to_back();
    cfg(2, 0, 1, 1);
    bus.io_mainTrigger = 1'b1;
    push_seq(2, 0, 1, 1);
    push_idle(1, 0);
    push_seq(2, 0, 1, 1);
    push_idle(2, 0);
    for (int i = 1; q.size() != 0; i++) begin
      @(negedge clk);
      e = q.pop_front(); vec++;
      if ({bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut} !== {e.busy, e.lend, e.pulse} ||
          (e.chk && bus.io_pulseIdx !== e.idx)) begin
        miss++;
        $display("FAIL back_to_back cyc %0d: busy/end/pulse/idx got %b%b%b/%0d want %b%b%b/%0d", i,
                 bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut, bus.io_pulseIdx, e.busy, e.lend, e.pulse, e.idx);
      end
      bus.io_mainTrigger = (i == 5);
    end
  endtask

  task automatic test_reset_mid_low();
    cfg(2, 0, 2, 4);
    bus.io_mainTrigger = 1'b1;
    push_seq(2, 0, 2, 4);
    while (q.size() > 4) void'(q.pop_back());
    push_idle(3, 1);
    for (int i = 1; q.size() != 0; i++) begin
      @(negedge clk);
      e = q.pop_front(); vec++;
      if ({bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut} !== {e.busy, e.lend, e.pulse} ||
          (e.chk && bus.io_pulseIdx !== e.idx)) begin
        miss++;
        $display("FAIL reset_mid cyc %0d: busy/end/pulse/idx got %b%b%b/%0d want %b%b%b/%0d", i,
                 bus.io_seqBusy, bus.io_logicEnd, bus.io_pulseOut, bus.io_pulseIdx, e.busy, e.lend, e.pulse, e.idx);
      end
      bus.io_mainTrigger = 1'b0;
      rst = (i == 4);
    end
  endtask

  task automatic test_full_scale();
    bus_s.io_pulseNo  = 4'd2;
    bus_s.io_delay    = 4'd15;
    bus_s.io_highTime = 4'd15;
    bus_s.io_lowTime  = 4'd15;
    bus_s.io_mainTrigger = 1'b1;
    push_seq(2, 15, 15, 15);
    push_idle(2, 0);
    for (int i = 1; q.size() != 0; i++) begin
      @(negedge clk);
      bus_s.io_mainTrigger = 1'b0;
      e = q.pop_front(); vec++;
      if ({bus_s.io_seqBusy, bus_s.io_logicEnd, bus_s.io_pulseOut} !== {e.busy, e.lend, e.pulse} ||
          (e.chk && {12'd0, bus_s.io_pulseIdx} !== e.idx)) begin
        miss++;
        $display("FAIL full_scale cyc %0d: busy/end/pulse/idx got %b%b%b/%0d want %b%b%b/%0d", i,
                 bus_s.io_seqBusy, bus_s.io_logicEnd, bus_s.io_pulseOut, bus_s.io_pulseIdx, e.busy, e.lend, e.pulse, e.idx);
      end
    end
  endtask

  initial begin
    vec  = 0;
    miss = 0;
    rst  = 1'b1;
    bus.io_mainTrigger = 1'b0;
    bus.io_rptEn       = 1'b0;
    bus.io_abort       = 1'b0;
    cfg(0, 0, 0, 0);
    bus_s.io_mainTrigger = 1'b0;
    bus_s.io_rptEn       = 1'b0;
    bus_s.io_abort       = 1'b0;
    bus_s.io_pulseNo     = '0;
    bus_s.io_delay       = '0;
    bus_s.io_highTime    = '0;
    bus_s.io_lowTime     = '0;

    test_reset();
    test_basic();
    test_rpt_delay();
    test_zero_num();
    test_retrigger_change();
    test_abort();
    test_back_to_back();
    test_reset_mid_low();
    test_full_scale();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/logic_pulse_seq.md
# logic_pulse_seq

Programmable pulse-train sequencer that plays one "logic" sequence: an optional start delay, then N pulses with configurable high and low widths. It is triggered by the main trigger or by the repeat controller's re-arm strobe. When the sequence completes it emits a single-cycle end strobe, which the repeat controller consumes to count repeats and time the next re-arm. This block sits directly upstream of the repeat controller and closes the trigger → sequence → end → re-arm loop.

## Interface
Parameters:
- CNT_W, 24, width of the delay, high-time and low-time counters
- NUM_W, 16, width of the pulse count and pulse index

Ports:
- io_clk  in  1  single clock; all logic is on its rising edge
- io_rst  in  1  synchronous, active-high reset
- io_mainTrigger  in  1  start strobe from the trigger source
- io_rptEn  in  1  re-arm strobe from the repeat controller; same effect as io_mainTrigger
- io_abort  in  1  cancels the running sequence
- io_pulseNo  in  NUM_W  number of pulses per sequence
- io_delay  in  CNT_W  cycles from start to the first pulse
- io_highTime  in  CNT_W  pulse high width, in cycles
- io_lowTime  in  CNT_W  gap between pulses, in cycles
- io_pulseOut  out  1  registered pulse output
- io_logicEnd  out  1  one-cycle strobe marking sequence completion
- io_seqBusy  out  1  high while a sequence is running
- io_pulseIdx  out  NUM_W  index of the current pulse, 0-based

## Operation
- FSM states: IDLE, DELAY, HIGH, LOW, END.
- Start condition: start = io_mainTrigger | io_rptEn, sampled only in IDLE.
  - Start is ignored in every other state.
  - Start is ignored when io_pulseNo == 0; no io_logicEnd is produced.
- On start, io_pulseNo, io_delay, io_highTime and io_lowTime are latched into shadow registers. Input changes during a sequence have no effect until the next start.
- Zero-value handling on the latched values:
  - delay == 0 skips DELAY and goes straight to HIGH.
  - highTime == 0 is treated as 1.
  - lowTime == 0 is treated as 1.
- DELAY: count `delay` cycles, then go to HIGH.
- HIGH: io_pulseOut = 1 for `highTime` cycles.
  - If io_pulseIdx == pulseNo−1, go to END; the low phase of the last pulse is skipped.
  - Otherwise go to LOW.
- LOW: io_pulseOut = 0 for `lowTime` cycles, then io_pulseIdx increments and the FSM goes to HIGH.
- END: io_logicEnd = 1 for exactly one cycle, then the FSM returns to IDLE.
- Counters are CNT_W bits wide and compare to the latched value minus 1. Full-scale values (2^CNT_W−1) must work without wrap.
- io_abort (lower priority than io_rst): the FSM goes to IDLE on the next edge. io_pulseOut and io_seqBusy drop, io_pulseIdx clears, and io_logicEnd is not asserted.
- io_abort together with start in IDLE: abort wins and no sequence starts.
- Reset values:
  - io_pulseOut = 0
  - io_logicEnd = 0
  - io_seqBusy = 0
  - io_pulseIdx = 0
  - FSM = IDLE, all counters = 0
- Reset mid-sequence behaves like abort, taking effect at the next edge.

## Timing
- Start sampled at edge t: io_seqBusy = 1 from t+1.
- First pulse: io_pulseOut rises at t+1+delay and stays high highTime cycles.
- Pulse period: highTime + lowTime cycles.
- io_logicEnd is asserted in the cycle immediately after the final high phase. In that same cycle io_seqBusy is still 1.
- io_seqBusy = 0 in the following cycle. A new start is accepted in that cycle, i.e. the first IDLE cycle.
- Total sequence length, from start edge to io_logicEnd: delay + pulseNo·highTime + (pulseNo−1)·lowTime cycles. The io_logicEnd cycle follows.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- The shared package holds:
  - the FSM state enum (IDLE/DELAY/HIGH/LOW/END)
  - CNT_W and NUM_W defaults, shared with the repeat controller so the time and count fields match
- One sub-module is natural: phase_timer, a loadable down-counter with a done flag. It is reused for the DELAY, HIGH and LOW phases.

## Test plan
- pulseNo=3, delay=0, high=2, low=3, trigger at cycle 10:
  - io_pulseOut high at cycles 11–12, 16–17, 21–22
  - io_logicEnd at cycle 23
  - io_seqBusy 11–23
- pulseNo=1, delay=5, high=0, low=7, triggered via io_rptEn at cycle 0:
  - one 1-cycle pulse at cycle 6
  - io_logicEnd at cycle 7
- pulseNo=0, trigger: no activity; io_seqBusy, io_pulseOut and io_logicEnd all stay 0.
- Mid-sequence cases:
  - Re-trigger while busy: ignored.
  - Change io_highTime mid-sequence: widths are unchanged.
  - io_abort during the 2nd pulse: outputs drop next cycle and no io_logicEnd is asserted.
- Back-to-back: trigger asserted in the first IDLE cycle after io_logicEnd is accepted. io_rst asserted mid-LOW returns all outputs to their reset values at the next edge.
- Full-scale check: high = 2^CNT_W−1 run to completion (in reduced-CNT_W config, CNT_W=4: high=15) gives an exact 15-cycle pulse.
